gen_cfg_sequencer: RTL and testbench

Sits between reg_bank and the GPS signal generator datapath (C/A code generator, NCO/doppler, noise/SNR mixer). It holds shadow copies of the generator configuration and controls start, stop and reconfiguration of the datapath. Configuration changes take effect only at C/A code epoch boundaries, signalled by code_phase_done_in. Changes to satellite or code phase trigger a full code reload and settle sequence.

---
 rtl/gen_cfg_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_gen_cfg_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gen_cfg_sequencer.sv
// Shadows generator config and sequences start/stop/reconfig of the GPS signal datapath on C/A epoch boundaries.
// Latency: gen_enable_out rises SETTLE_CYCLES+1 clocks after capture; minor changes apply in the capture clock.
// Backpressure: no handshake; a change waits in PEND for code_phase_done_in, or is forced after EPOCH_TIMEOUT clocks.
module gen_cfg_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int EPOCH_TIMEOUT = 20000
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        enable_in,
  input  logic [4:0]  n_sat_in,
  input  logic [9:0]  ca_phase_in,
  input  logic [15:0] doppler_in,
  input  logic [7:0]  snr_in,
  input  logic        use_preset_in,
  input  logic        use_msg_preset_in,
  input  logic        noise_off_in,
  input  logic        signal_off_in,
  input  logic        code_phase_done_in,
  output logic        gen_enable_out,
  output logic        ca_load_out,
  output logic [4:0]  n_sat_out,
  output logic [9:0]  ca_phase_out,
  output logic [15:0] doppler_out,
  output logic [7:0]  snr_out,
  output logic        use_preset_out,
  output logic        use_msg_preset_out,
  output logic        noise_off_out,
  output logic        signal_off_out,
  output logic        cfg_pending_out,
  output logic        timeout_out
);

  localparam int TW = $clog2(EPOCH_TIMEOUT + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST      = TW'(EPOCH_TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX       = TW'(EPOCH_TIMEOUT);

  typedef struct packed {
    logic [4:0]  n_sat;
    logic [9:0]  ca_phase;
    logic [15:0] doppler;
    logic [7:0]  snr;
    logic        use_preset;
    logic        use_msg_preset;
    logic        noise_off;
    logic        signal_off;
  } cfg_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    PEND   = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t          state;
  cfg_t            live;
  cfg_t            shadow;
  logic [SW-1:0]   settle_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            major_chg;
  logic            minor_chg;
  logic            any_chg;
  logic            tmo_hit;

  assign live = {n_sat_in, ca_phase_in, doppler_in, snr_in,
                 use_preset_in, use_msg_preset_in, noise_off_in, signal_off_in};

  // Classify the difference between live request and what the datapath is running with.
  always_comb begin
    major_chg = (live.n_sat != shadow.n_sat) || (live.ca_phase != shadow.ca_phase);
    minor_chg = (live.doppler != shadow.doppler) || (live.snr != shadow.snr) ||
                (live.use_preset != shadow.use_preset) ||
                (live.use_msg_preset != shadow.use_msg_preset) ||
                (live.noise_off != shadow.noise_off) ||
                (live.signal_off != shadow.signal_off);
    any_chg   = major_chg || minor_chg;
    tmo_hit   = (tmo_cnt == T_LAST);
  end

  // Sequencer: all outputs registered; shadow only changes on a capture.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state           <= IDLE;
      shadow          <= '0;
      settle_cnt      <= '0;
      tmo_cnt         <= '0;
      gen_enable_out  <= 1'b0;
      ca_load_out     <= 1'b0;
      cfg_pending_out <= 1'b0;
      timeout_out     <= 1'b0;
    end else begin
      ca_load_out <= 1'b0;
      case (state)
        IDLE: begin
          gen_enable_out <= 1'b0;
          if (enable_in) begin
            shadow      <= live;
            ca_load_out <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          settle_cnt <= SETTLE_INIT;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            gen_enable_out <= 1'b1;
            state          <= RUN;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        RUN: begin
          if (!enable_in) begin
            tmo_cnt <= '0;
            state   <= STOP;
          end else if (any_chg && code_phase_done_in) begin
            shadow <= live;
            if (major_chg) begin
              ca_load_out    <= 1'b1;
              gen_enable_out <= 1'b0;
              state          <= LOAD;
            end
          end else if (any_chg) begin
            cfg_pending_out <= 1'b1;
            tmo_cnt         <= '0;
            state           <= PEND;
          end
        end
        PEND: begin
          if (!enable_in) begin
            cfg_pending_out <= 1'b0;
            tmo_cnt         <= '0;
            state           <= STOP;
          end else if (code_phase_done_in || tmo_hit) begin
            // A forced apply is flagged only when the boundary never came.
            if (!code_phase_done_in) timeout_out <= 1'b1;
            shadow          <= live;
            cfg_pending_out <= 1'b0;
            if (major_chg) begin
              ca_load_out    <= 1'b1;
              gen_enable_out <= 1'b0;
              state          <= LOAD;
            end else begin
              state <= RUN;
            end
          end else if (!any_chg) begin
            cfg_pending_out <= 1'b0;
            state           <= RUN;
          end else if (tmo_cnt != T_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        STOP: begin
          // Keep the datapath running until the epoch completes, then park.
          if (code_phase_done_in || tmo_hit) begin
            if (!code_phase_done_in) timeout_out <= 1'b1;
            gen_enable_out <= 1'b0;
            state          <= IDLE;
          end else if (tmo_cnt != T_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          gen_enable_out <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

  assign n_sat_out          = shadow.n_sat;
  assign ca_phase_out       = shadow.ca_phase;
  assign doppler_out        = shadow.doppler;
  assign snr_out            = shadow.snr;
  assign use_preset_out     = shadow.use_preset;
  assign use_msg_preset_out = shadow.use_msg_preset;
  assign noise_off_out      = shadow.noise_off;
  assign signal_off_out     = shadow.signal_off;

endmodule

// File: tb/tb_gen_cfg_sequencer.sv
// Bench for gen_cfg_sequencer: directed scenarios followed by random traffic.
// Every cycle the DUT outputs are compared against a behavioural model.
module tb_gen_cfg_sequencer;

  localparam int SC = 4;
  localparam int ET = 50;

  logic        clk_in = 1'b0;
  logic        rst_in_n = 1'b0;
  logic        enable_in = 1'b0;
  logic [4:0]  n_sat_in = '0;
  logic [9:0]  ca_phase_in = '0;
  logic [15:0] doppler_in = '0;
  logic [7:0]  snr_in = '0;
  logic        use_preset_in = 1'b0;
  logic        use_msg_preset_in = 1'b0;
  logic        noise_off_in = 1'b0;
  logic        signal_off_in = 1'b0;
  logic        code_phase_done_in = 1'b0;
  logic        gen_enable_out, ca_load_out;
  logic [4:0]  n_sat_out;
  logic [9:0]  ca_phase_out;
  logic [15:0] doppler_out;
  logic [7:0]  snr_out;
  logic        use_preset_out, use_msg_preset_out, noise_off_out, signal_off_out;
  logic        cfg_pending_out, timeout_out;

  gen_cfg_sequencer #(.SETTLE_CYCLES(SC), .EPOCH_TIMEOUT(ET)) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .enable_in(enable_in),
    .n_sat_in(n_sat_in), .ca_phase_in(ca_phase_in), .doppler_in(doppler_in),
    .snr_in(snr_in), .use_preset_in(use_preset_in), .use_msg_preset_in(use_msg_preset_in),
    .noise_off_in(noise_off_in), .signal_off_in(signal_off_in),
    .code_phase_done_in(code_phase_done_in),
    .gen_enable_out(gen_enable_out), .ca_load_out(ca_load_out),
    .n_sat_out(n_sat_out), .ca_phase_out(ca_phase_out), .doppler_out(doppler_out),
    .snr_out(snr_out), .use_preset_out(use_preset_out),
    .use_msg_preset_out(use_msg_preset_out), .noise_off_out(noise_off_out),
    .signal_off_out(signal_off_out), .cfg_pending_out(cfg_pending_out),
    .timeout_out(timeout_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [4:0]  n_sat;
    logic [9:0]  ca_phase;
    logic [15:0] doppler;
    logic [7:0]  snr;
    logic [3:0]  flags;
  } cfg_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  cfg_t live;
  always_comb live = {n_sat_in, ca_phase_in, doppler_in, snr_in,
                      use_preset_in, use_msg_preset_in, noise_off_in, signal_off_in};

  // Behavioural model: running / reloading / pending / stopping as plain flags and counters.
  bit   m_active = 0;   // a start has been accepted and not yet parked
  int   m_reload = 0;   // clocks left with the datapath held off for reload
  bit   m_stop = 0;     // run request dropped, waiting for epoch end
  bit   m_pend = 0;     // change waiting for epoch end
  int   m_age = 0;      // clocks spent waiting
  bit   m_tout = 0;
  cfg_t m_cfg = '0;

  always @(posedge clk_in or negedge rst_in_n) begin : model
    bit chg, big, edge_now;
    if (!rst_in_n) begin
      m_active = 0; m_reload = 0; m_stop = 0; m_pend = 0; m_age = 0; m_tout = 0; m_cfg = '0;
    end else begin
      chg = (live != m_cfg);
      big = (live.n_sat != m_cfg.n_sat) || (live.ca_phase != m_cfg.ca_phase);
      edge_now = code_phase_done_in;
      if (!m_active) begin
        if (enable_in) begin m_cfg = live; m_active = 1; m_reload = SC + 1; end
      end else if (m_reload > 0) begin
        m_reload--;
      end else if (m_stop) begin
        if (edge_now || m_age == ET - 1) begin
          if (!edge_now) m_tout = 1;
          m_active = 0; m_stop = 0;
        end else m_age++;
      end else if (m_pend) begin
        if (!enable_in) begin m_pend = 0; m_stop = 1; m_age = 0; end
        else if (edge_now || m_age == ET - 1) begin
          if (!edge_now) m_tout = 1;
          if (big) m_reload = SC + 1;
          m_cfg = live; m_pend = 0;
        end else if (!chg) m_pend = 0;
        else m_age++;
      end else begin
        if (!enable_in) begin m_stop = 1; m_age = 0; end
        else if (chg && edge_now) begin
          if (big) m_reload = SC + 1;
          m_cfg = live;
        end else if (chg) begin m_pend = 1; m_age = 0; end
      end
    end
  end

  logic [48:0] dut_vec, exp_vec;
  assign dut_vec = {gen_enable_out, ca_load_out, cfg_pending_out, timeout_out,
                    n_sat_out, ca_phase_out, doppler_out, snr_out,
                    use_preset_out, use_msg_preset_out, noise_off_out, signal_off_out};
  assign exp_vec = {(m_active && m_reload == 0), (m_reload == SC + 1), m_pend, m_tout, m_cfg};

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk_in) chk("cycle", 64'(dut_vec), 64'(exp_vec));

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic rand_drive();
    code_phase_done_in = ($urandom_range(0, 29) == 0);
    if ($urandom_range(0, 79) == 0) enable_in = ~enable_in;
    case ($urandom_range(0, 39))
      0: n_sat_in = 5'($urandom);
      1: ca_phase_in = 10'($urandom_range(0, 1022));
      2: doppler_in = 16'($urandom);
      3: snr_in = 8'($urandom);
      4: {use_preset_in, use_msg_preset_in, noise_off_in, signal_off_in} = 4'($urandom);
      5: {n_sat_in, ca_phase_in, doppler_in, snr_in,
          use_preset_in, use_msg_preset_in, noise_off_in, signal_off_in} = m_cfg;
      default: ;
    endcase
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("reset_outs", 64'(dut_vec), 64'(0));

    // 1: startup
    n_sat_in = 5; ca_phase_in = 100; enable_in = 1;
    rst_in_n = 1;
    tick(1);
    chk("t1_load", 64'(ca_load_out), 64'(1));
    chk("t1_gen_lo", 64'(gen_enable_out), 64'(0));
    for (int i = 0; i < SC; i++) begin
      tick(1);
      chk("t1_settle", 64'({gen_enable_out, ca_load_out}), 64'(0));
    end
    tick(1);
    chk("t1_gen_hi", 64'(gen_enable_out), 64'(1));
    chk("t1_cfg", 64'({n_sat_out, ca_phase_out}), 64'({5'd5, 10'd100}));

    // 2: minor change waits for the boundary
    doppler_in = 16'hFC18;
    tick(1);
    chk("t2_pend", 64'(cfg_pending_out), 64'(1));
    chk("t2_dop_old", 64'(doppler_out), 64'(0));
    code_phase_done_in = 1;
    tick(1);
    code_phase_done_in = 0;
    chk("t2_dop_new", 64'(doppler_out), 64'(16'hFC18));
    chk("t2_flags", 64'({cfg_pending_out, ca_load_out, gen_enable_out}), 64'(3'b001));

    // 3: major change coincident with the boundary
    n_sat_in = 12; code_phase_done_in = 1;
    tick(1);
    code_phase_done_in = 0;
    chk("t3_load", 64'(ca_load_out), 64'(1));
    chk("t3_nsat", 64'(n_sat_out), 64'(12));
    for (int i = 0; i < SC + 1; i++) begin
      if (i > 0) tick(1);
      chk("t3_gen_lo", 64'(gen_enable_out), 64'(0));
    end
    tick(1);
    chk("t3_gen_hi", 64'(gen_enable_out), 64'(1));

    // 4: timeout forces the apply
    snr_in = 8'd77;
    tick(1);
    chk("t4_pend", 64'(cfg_pending_out), 64'(1));
    tick(ET - 1);
    chk("t4_not_yet", 64'({timeout_out, snr_out}), 64'({1'b0, 8'd0}));
    tick(1);
    chk("t4_tout", 64'({timeout_out, snr_out, cfg_pending_out}), 64'({1'b1, 8'd77, 1'b0}));

    // 5: stop waits for the epoch end, re-raised enable ignored until idle
    enable_in = 0;
    tick(4);
    chk("t5_hold", 64'(gen_enable_out), 64'(1));
    enable_in = 1;
    tick(1);
    chk("t5_ignored", 64'({gen_enable_out, ca_load_out}), 64'(2'b10));
    code_phase_done_in = 1;
    tick(1);
    code_phase_done_in = 0;
    chk("t5_off", 64'(gen_enable_out), 64'(0));
    tick(1);
    chk("t5_restart", 64'(ca_load_out), 64'(1));

    // 6: asynchronous reset in the middle of settling
    tick(2);
    #2 rst_in_n = 0;
    #1 chk("t6_async", 64'(dut_vec), 64'(0));
    @(negedge clk_in);
    enable_in = 0;
    @(negedge clk_in);
    rst_in_n = 1;
    tick(2);
    chk("t6_idle", 64'({gen_enable_out, ca_load_out}), 64'(0));
    enable_in = 1;
    tick(1);
    chk("t6_load", 64'({ca_load_out, n_sat_out}), 64'({1'b1, 5'd12}));

    // Random traffic checked every cycle by the model comparison
    repeat (4000) begin
      @(negedge clk_in);
      rand_drive();
    end
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
